mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15: maximum cycles a memory access may wait for mem_ready before fault.
REQ-002 SHALL have parameter EN_EXT_OPS, default 1: 1 enables bne and addi decode; 0 treats them as illegal.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 op  in  6  instruction opcode, taken from the latched instruction register.
REQ-006 funct  in  6  R-type function field.
REQ-007 zero  in  1  ALU zero flag.
REQ-008 mem_ready  in  1  unified memory completes the current access this cycle.
REQ-009 pcen, iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca  out  1 each  datapath strobes and mux selects.
REQ-010 alusrcb  out  2; pcsrc  out  2; alucontrol  out  3.
REQ-011 fault  out  1  sticky error flag; state  out  4  current FSM state for debug.

Function
REQ-012 SHALL be a multicycle Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP and FAULT; all strobes SHALL default to 0.
REQ-013 FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, aluop=add, pcsrc=00; irwrite and pc write SHALL assert only in a cycle with mem_ready=1, and the FSM then goes to DECODE; otherwise it stays in FETCH.
REQ-014 DECODE: alusrca=0, alusrcb=11, aluop=add; next state by op: 100011/101011 -> MEMADR, 000000 -> EXECUTE, 000100/000101 -> BRANCH, 001000 -> ADDIEXEC, 000010 -> JUMP; any other op -> FAULT.
REQ-015 MEMADR: alusrca=1, alusrcb=10, aluop=add; lw -> MEMRD, sw -> MEMWR.
REQ-016 MEMRD: iord=1, memread=1; wait for mem_ready, then MEMWB. MEMWB: regdst=0, memtoreg=1, regwrite=1 -> FETCH.
REQ-017 MEMWR: iord=1, memwrite=1 held until mem_ready, then FETCH.
REQ-018 EXECUTE: alusrca=1, alusrcb=00, aluop=funct -> ALUWB. ALUWB: regdst=1, memtoreg=0, regwrite=1 -> FETCH.
REQ-019 BRANCH: alusrca=1, alusrcb=00, aluop=sub, pcsrc=01; pcen=zero for beq and pcen=~zero for bne, combinationally -> FETCH.
REQ-020 ADDIEXEC: alusrca=1, alusrcb=10, aluop=add -> ADDIWB. ADDIWB: regdst=0, memtoreg=0, regwrite=1 -> FETCH.
REQ-021 JUMP: pcsrc=10, pcen=1 -> FETCH.
REQ-022 pcen SHALL equal pcwrite | (beq & zero) | (bne & ~zero).
REQ-023 alucontrol: aluop add -> 010, sub -> 110; funct 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111; unknown funct in EXECUTE SHALL route to FAULT instead of ALUWB, with no regwrite.
REQ-024 A wait counter SHALL clear on entry to FETCH, MEMRD or MEMWR and increment each cycle mem_ready=0; when it reaches MEM_TIMEOUT with mem_ready still 0, the FSM SHALL go to FAULT next cycle with no commit strobe asserted.
REQ-025 mem_ready arriving in the same cycle the counter reaches MEM_TIMEOUT SHALL complete the access normally (ready wins).
REQ-026 FAULT SHALL hold all strobes 0 and fault=1 until reset; counter width = clog2(MEM_TIMEOUT+1).
REQ-027 mem_ready outside FETCH/MEMRD/MEMWR SHALL be ignored.

Reset
REQ-028 reset=1 at a clock edge SHALL force state=FETCH, counter=0 and fault=0, from any state including mid-access and FAULT.
REQ-029 During the reset cycle all write strobes (pcen, irwrite, regwrite, memwrite) SHALL be 0.

Structure
REQ-030 State encodings, opcode constants, funct constants and alucontrol codes SHALL live in shared package mc_pkg.
REQ-031 ALU decode SHALL be a combinational sub-module mc_aludec (aluop, funct -> alucontrol, illegal).

Verification
REQ-032 lw with mem_ready=1 immediately: op=100011 -> FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1, memtoreg=1 in MEMWB; 5 cycles total.
REQ-033 sw with mem_ready delayed 3 cycles in MEMWR -> memwrite held 4 cycles, then FETCH, fault=0.
REQ-034 bne (EN_EXT_OPS=1) with zero=0 -> pcen=1 and pcsrc=01 in BRANCH; with zero=1 -> pcen=0.
REQ-035 MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> FAULT after 4 wait cycles, fault=1, irwrite never asserted; then reset=1 -> FETCH, fault=0.
REQ-036 op=111111, or funct=000000 with op=000000 -> FAULT with no regwrite; EN_EXT_OPS=0 with op=001000 -> FAULT.
REQ-037 reset asserted in MEMWR while waiting -> next cycle state=FETCH and memwrite=0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle controller: FSM states, opcodes,
// funct codes and ALU control encodings.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11,
        S_FAULT    = 4'd12
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_FUNCT = 2'd2
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // R-type decode table: entry i maps FN_TABLE[i] to ALU_TABLE[i]
    localparam int FN_COUNT = 5;
    localparam logic [5:0] FN_TABLE  [FN_COUNT] = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
    localparam logic [2:0] ALU_TABLE [FN_COUNT] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT};

endpackage

// File: rtl/mc_aludec.sv
// Combinational ALU decoder: maps aluop/funct to an alucontrol code and
// flags funct values that have no ALU operation.
module mc_aludec
    import mc_pkg::*;
(
    input  aluop_t      aluop,
    input  logic [5:0]  funct,
    output logic [2:0]  alucontrol,
    output logic        illegal
);

    logic [FN_COUNT-1:0] hit;
    logic [2:0]          funct_code;

    generate
        for (genvar gi = 0; gi < FN_COUNT; gi++) begin : g_fn
            assign hit[gi] = (funct == FN_TABLE[gi]);
        end
    endgenerate

    always_comb begin
        funct_code = ALU_ADD;
        for (int i = 0; i < FN_COUNT; i++) begin
            if (hit[i]) funct_code = ALU_TABLE[i];
        end
    end

    always_comb begin
        alucontrol = ALU_ADD;
        illegal    = 1'b0;
        case (aluop)
            ALUOP_ADD:   alucontrol = ALU_ADD;
            ALUOP_SUB:   alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                alucontrol = funct_code;
                illegal    = ~|hit;
            end
            default:     alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle Moore control FSM with unified-memory handshake, a bounded
// wait counter on memory accesses and a sticky FAULT state.
module mc_controller
    import mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int EN_EXT_OPS  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pcen,
    output logic        iord,
    output logic        memread,
    output logic        memwrite,
    output logic        irwrite,
    output logic        regdst,
    output logic        memtoreg,
    output logic        regwrite,
    output logic        alusrca,
    output logic [1:0]  alusrcb,
    output logic [1:0]  pcsrc,
    output logic [2:0]  alucontrol,
    output logic        fault,
    output logic [3:0]  state
);

    localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
    aluop_t           aluop;
    logic             funct_illegal;
    logic             pcwrite;
    logic             ext_ok, is_beq, is_bne;
    logic             wait_state, timed_out, branch_take;

    mc_aludec u_aludec (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol),
        .illegal    (funct_illegal)
    );

    assign ext_ok     = (EN_EXT_OPS != 0);
    assign is_beq     = (op == OP_BEQ);
    assign is_bne     = ext_ok && (op == OP_BNE);
    assign wait_state = state_reg inside {S_FETCH, S_MEMRD, S_MEMWR};
    // ready in the final counted cycle still completes the access
    assign timed_out  = wait_state && !mem_ready && (wait_cnt_reg == CNT_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_FETCH;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // Any state change starts the next wait state with a clean count
    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (state_next != state_reg)
            wait_cnt_next = '0;
        else if (wait_state && !mem_ready && (wait_cnt_reg != CNT_MAX))
            wait_cnt_next = wait_cnt_reg + 1'b1;
    end

    always_comb begin
        state_next = state_reg;
        aluop      = ALUOP_ADD;
        pcwrite    = 1'b0;
        iord       = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;

        case (state_reg)
            S_FETCH: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                if (mem_ready) begin
                    irwrite    = 1'b1;
                    pcwrite    = 1'b1;
                    state_next = S_DECODE;
                end else if (timed_out) begin
                    state_next = S_FAULT;
                end
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXECUTE;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_BNE:       state_next = ext_ok ? S_BRANCH : S_FAULT;
                    OP_ADDI:      state_next = ext_ok ? S_ADDIEXEC : S_FAULT;
                    OP_J:         state_next = S_JUMP;
                    default:      state_next = S_FAULT;
                endcase
            end
            S_MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                memread = 1'b1;
                if (mem_ready)      state_next = S_MEMWB;
                else if (timed_out) state_next = S_FAULT;
            end
            S_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                if (mem_ready)      state_next = S_FETCH;
                else if (timed_out) state_next = S_FAULT;
            end
            S_EXECUTE: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_FUNCT;
                state_next = funct_illegal ? S_FAULT : S_ALUWB;
            end
            S_ALUWB: begin
                regdst     = 1'b1;
                regwrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_SUB;
                pcsrc      = 2'b01;
                state_next = S_FETCH;
            end
            S_ADDIEXEC: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                state_next = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_JUMP: begin
                pcsrc      = 2'b10;
                pcwrite    = 1'b1;
                state_next = S_FETCH;
            end
            S_FAULT: state_next = S_FAULT;
            default: state_next = S_FAULT;
        endcase

        branch_take = (state_reg == S_BRANCH) && ((is_beq && zero) || (is_bne && !zero));
        pcen        = pcwrite | branch_take;

        // Nothing may commit in the cycle reset is being applied
        if (reset) begin
            pcen     = 1'b0;
            irwrite  = 1'b0;
            regwrite = 1'b0;
            memwrite = 1'b0;
        end
    end

    assign fault = (state_reg == S_FAULT);
    assign state = state_reg;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: dut_a has a short timeout with extended
// ops on, dut_b uses default timeout with extended ops off; inputs are shared.
module tb_mc_controller;
    import mc_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'b0;
    logic [5:0] funct = 6'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;

    logic       a_pcen, a_iord, a_memread, a_memwrite, a_irwrite, a_regdst, a_memtoreg, a_regwrite, a_alusrca;
    logic [1:0] a_alusrcb, a_pcsrc;
    logic [2:0] a_alucontrol;
    logic       a_fault;
    logic [3:0] a_state;

    logic       b_pcen, b_iord, b_memread, b_memwrite, b_irwrite, b_regdst, b_memtoreg, b_regwrite, b_alusrca;
    logic [1:0] b_alusrcb, b_pcsrc;
    logic [2:0] b_alucontrol;
    logic       b_fault;
    logic [3:0] b_state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mc_controller #(.MEM_TIMEOUT(4), .EN_EXT_OPS(1)) dut_a (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pcen(a_pcen), .iord(a_iord), .memread(a_memread), .memwrite(a_memwrite),
        .irwrite(a_irwrite), .regdst(a_regdst), .memtoreg(a_memtoreg), .regwrite(a_regwrite),
        .alusrca(a_alusrca), .alusrcb(a_alusrcb), .pcsrc(a_pcsrc), .alucontrol(a_alucontrol),
        .fault(a_fault), .state(a_state)
    );

    mc_controller #(.EN_EXT_OPS(0)) dut_b (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pcen(b_pcen), .iord(b_iord), .memread(b_memread), .memwrite(b_memwrite),
        .irwrite(b_irwrite), .regdst(b_regdst), .memtoreg(b_memtoreg), .regwrite(b_regwrite),
        .alusrca(b_alusrca), .alusrcb(b_alusrcb), .pcsrc(b_pcsrc), .alucontrol(b_alucontrol),
        .fault(b_fault), .state(b_state)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'b0;
        zero = 1'b0;
        step();
        reset = 1'b0;
        #1;
    endtask

    // One-cycle fetch of opcode o on dut_a, then confirm arrival in DECODE
    task automatic fetch_to_decode(input logic [5:0] o);
        op = o;
        mem_ready = 1'b1;
        #1;
        total++;
        if (a_state !== S_FETCH || a_irwrite !== 1'b1 || a_pcen !== 1'b1 || a_memread !== 1'b1 || a_alusrcb !== 2'b01) begin
            bad++;
            $display("FAIL fetch op=%b state=%0d irwrite=%b pcen=%b memread=%b alusrcb=%b required state=0 1 1 1 01",
                     o, a_state, a_irwrite, a_pcen, a_memread, a_alusrcb);
        end
        step();
        total++;
        if (a_state !== S_DECODE || a_alusrcb !== 2'b11 || a_alucontrol !== 3'b010) begin
            bad++;
            $display("FAIL decode op=%b state=%0d alusrcb=%b alucontrol=%b required 1 11 010", o, a_state, a_alusrcb, a_alucontrol);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mem_ready = 1'b1;
        op = OP_LW;
        step();
        total++;
        if (a_state !== S_FETCH || a_fault !== 1'b0 || b_state !== S_FETCH) begin
            bad++;
            $display("FAIL reset_state a=%0d b=%0d fault=%b required 0 0 0", a_state, b_state, a_fault);
        end
        total++;
        if (a_pcen !== 1'b0 || a_irwrite !== 1'b0 || a_regwrite !== 1'b0 || a_memwrite !== 1'b0) begin
            bad++;
            $display("FAIL reset_strobes pcen=%b irwrite=%b regwrite=%b memwrite=%b required all 0",
                     a_pcen, a_irwrite, a_regwrite, a_memwrite);
        end
        reset = 1'b0;
        mem_ready = 1'b0;
        #1;
        $display("txn reset: state=%0d fault=%b", a_state, a_fault);
    endtask

    task automatic test_lw();
        int cycles;
        do_reset();
        fetch_to_decode(OP_LW);
        step();
        total++;
        if (a_state !== S_MEMADR || a_alusrca !== 1'b1 || a_alusrcb !== 2'b10) begin
            bad++;
            $display("FAIL lw_memadr state=%0d alusrca=%b alusrcb=%b required 2 1 10", a_state, a_alusrca, a_alusrcb);
        end
        step();
        total++;
        if (a_state !== S_MEMRD || a_iord !== 1'b1 || a_memread !== 1'b1 || a_regwrite !== 1'b0) begin
            bad++;
            $display("FAIL lw_memrd state=%0d iord=%b memread=%b regwrite=%b required 3 1 1 0", a_state, a_iord, a_memread, a_regwrite);
        end
        step();
        total++;
        if (a_state !== S_MEMWB || a_regwrite !== 1'b1 || a_memtoreg !== 1'b1 || a_regdst !== 1'b0) begin
            bad++;
            $display("FAIL lw_memwb state=%0d regwrite=%b memtoreg=%b regdst=%b required 4 1 1 0", a_state, a_regwrite, a_memtoreg, a_regdst);
        end
        step();
        cycles = 5;
        total++;
        if (a_state !== S_FETCH) begin
            bad++;
            $display("FAIL lw_done state=%0d required 0 after %0d cycles", a_state, cycles);
        end
        $display("txn lw: cycles=%0d final_state=%0d", cycles, a_state);
    endtask

    task automatic test_sw_delay();
        int n = 0;
        do_reset();
        fetch_to_decode(OP_SW);
        mem_ready = 1'b0;
        step();
        step();
        total++;
        if (a_state !== S_MEMWR || a_iord !== 1'b1) begin
            bad++;
            $display("FAIL sw_enter state=%0d iord=%b required 5 1", a_state, a_iord);
        end
        for (int c = 0; c < 10; c++) begin
            if (c == 3) mem_ready = 1'b1;
            #1;
            if (a_state !== S_MEMWR) break;
            if (a_memwrite === 1'b1) n++;
            step();
        end
        mem_ready = 1'b0;
        total++;
        if (n !== 4 || a_state !== S_FETCH || a_fault !== 1'b0) begin
            bad++;
            $display("FAIL sw_delay memwrite_cycles=%0d state=%0d fault=%b required 4 0 0", n, a_state, a_fault);
        end
        $display("txn sw: memwrite_cycles=%0d state=%0d", n, a_state);
    endtask

    task automatic test_branch();
        logic [5:0] ops [4] = '{OP_BNE, OP_BNE, OP_BEQ, OP_BEQ};
        logic       zs  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic       exp [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            do_reset();
            fetch_to_decode(ops[i]);
            step();
            zero = zs[i];
            #1;
            total++;
            if (a_state !== S_BRANCH || a_pcen !== exp[i] || a_pcsrc !== 2'b01 || a_alucontrol !== 3'b110) begin
                bad++;
                $display("FAIL branch op=%b zero=%b state=%0d pcen=%b pcsrc=%b alu=%b required 8 %b 01 110",
                         ops[i], zs[i], a_state, a_pcen, a_pcsrc, a_alucontrol, exp[i]);
            end
            total++;
            if (b_state !== ((ops[i] == OP_BNE) ? S_FAULT : S_BRANCH)) begin
                bad++;
                $display("FAIL branch_noext op=%b b_state=%0d", ops[i], b_state);
            end
            step();
            total++;
            if (a_state !== S_FETCH) begin
                bad++;
                $display("FAIL branch_done state=%0d required 0", a_state);
            end
            $display("txn branch: op=%b zero=%b pcen=%b", ops[i], zs[i], exp[i]);
        end
        zero = 1'b0;
    endtask

    task automatic test_rtype();
        logic [5:0] fns  [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        logic [2:0] alus [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            funct = fns[i];
            fetch_to_decode(OP_RTYPE);
            step();
            total++;
            if (a_state !== S_EXECUTE || a_alucontrol !== alus[i] || a_alusrca !== 1'b1 || a_alusrcb !== 2'b00 || a_regwrite !== 1'b0) begin
                bad++;
                $display("FAIL rtype_exec funct=%b state=%0d alu=%b alusrca=%b alusrcb=%b regwrite=%b required 6 %b 1 00 0",
                         fns[i], a_state, a_alucontrol, a_alusrca, a_alusrcb, a_regwrite, alus[i]);
            end
            step();
            total++;
            if (a_state !== S_ALUWB || a_regwrite !== 1'b1 || a_regdst !== 1'b1 || a_memtoreg !== 1'b0) begin
                bad++;
                $display("FAIL rtype_wb funct=%b state=%0d regwrite=%b regdst=%b memtoreg=%b required 7 1 1 0",
                         fns[i], a_state, a_regwrite, a_regdst, a_memtoreg);
            end
            step();
            $display("txn rtype: funct=%b alucontrol=%b", fns[i], alus[i]);
        end
    endtask

    task automatic test_addi_jump();
        do_reset();
        fetch_to_decode(OP_ADDI);
        step();
        total++;
        if (a_state !== S_ADDIEXEC || a_alusrcb !== 2'b10 || a_alusrca !== 1'b1 || a_alucontrol !== 3'b010) begin
            bad++;
            $display("FAIL addi_exec state=%0d alusrcb=%b alusrca=%b alu=%b required 9 10 1 010", a_state, a_alusrcb, a_alusrca, a_alucontrol);
        end
        total++;
        if (b_state !== S_FAULT || b_fault !== 1'b1) begin
            bad++;
            $display("FAIL addi_noext b_state=%0d b_fault=%b required 12 1", b_state, b_fault);
        end
        step();
        total++;
        if (a_state !== S_ADDIWB || a_regwrite !== 1'b1 || a_regdst !== 1'b0 || a_memtoreg !== 1'b0) begin
            bad++;
            $display("FAIL addi_wb state=%0d regwrite=%b regdst=%b memtoreg=%b required 10 1 0 0", a_state, a_regwrite, a_regdst, a_memtoreg);
        end
        step();
        fetch_to_decode(OP_J);
        step();
        total++;
        if (a_state !== S_JUMP || a_pcen !== 1'b1 || a_pcsrc !== 2'b10) begin
            bad++;
            $display("FAIL jump state=%0d pcen=%b pcsrc=%b required 11 1 10", a_state, a_pcen, a_pcsrc);
        end
        step();
        total++;
        if (a_state !== S_FETCH) begin
            bad++;
            $display("FAIL jump_done state=%0d required 0", a_state);
        end
        $display("txn addi+jump: state=%0d", a_state);
    endtask

    task automatic test_timeout();
        int irw = 0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            total++;
            if (a_state !== S_FETCH) begin
                bad++;
                $display("FAIL timeout_wait cycle=%0d state=%0d required 0", i, a_state);
            end
            if (a_irwrite === 1'b1) irw++;
            step();
        end
        total++;
        if (a_state !== S_FAULT || a_fault !== 1'b1 || irw !== 0) begin
            bad++;
            $display("FAIL timeout_fault state=%0d fault=%b irwrite_cycles=%0d required 12 1 0", a_state, a_fault, irw);
        end
        mem_ready = 1'b1;
        #1;
        total++;
        if (a_irwrite !== 1'b0 || a_pcen !== 1'b0 || a_memread !== 1'b0) begin
            bad++;
            $display("FAIL fault_strobes irwrite=%b pcen=%b memread=%b required 0 0 0", a_irwrite, a_pcen, a_memread);
        end
        step();
        total++;
        if (a_state !== S_FAULT) begin
            bad++;
            $display("FAIL fault_sticky state=%0d required 12", a_state);
        end
        do_reset();
        total++;
        if (a_state !== S_FETCH || a_fault !== 1'b0) begin
            bad++;
            $display("FAIL fault_clear state=%0d fault=%b required 0 0", a_state, a_fault);
        end
        $display("txn timeout: faulted then cleared, state=%0d", a_state);
    endtask

    task automatic test_ready_wins();
        do_reset();
        for (int i = 0; i < 4; i++) step();
        mem_ready = 1'b1;
        op = OP_J;
        #1;
        total++;
        if (a_state !== S_FETCH || a_irwrite !== 1'b1) begin
            bad++;
            $display("FAIL ready_wins state=%0d irwrite=%b required 0 1", a_state, a_irwrite);
        end
        step();
        total++;
        if (a_state !== S_DECODE || a_fault !== 1'b0) begin
            bad++;
            $display("FAIL ready_wins_next state=%0d fault=%b required 1 0", a_state, a_fault);
        end
        $display("txn ready_wins: state=%0d", a_state);
    endtask

    task automatic test_illegal();
        do_reset();
        fetch_to_decode(6'b111111);
        step();
        total++;
        if (a_state !== S_FAULT || a_fault !== 1'b1 || a_regwrite !== 1'b0) begin
            bad++;
            $display("FAIL illegal_op state=%0d fault=%b regwrite=%b required 12 1 0", a_state, a_fault, a_regwrite);
        end
        do_reset();
        funct = 6'b000000;
        fetch_to_decode(OP_RTYPE);
        step();
        total++;
        if (a_state !== S_EXECUTE || a_regwrite !== 1'b0) begin
            bad++;
            $display("FAIL illegal_funct_exec state=%0d regwrite=%b required 6 0", a_state, a_regwrite);
        end
        step();
        total++;
        if (a_state !== S_FAULT || a_fault !== 1'b1 || a_regwrite !== 1'b0) begin
            bad++;
            $display("FAIL illegal_funct state=%0d fault=%b regwrite=%b required 12 1 0", a_state, a_fault, a_regwrite);
        end
        $display("txn illegal: state=%0d", a_state);
    endtask

    task automatic test_reset_memwr();
        do_reset();
        fetch_to_decode(OP_SW);
        mem_ready = 1'b0;
        step();
        step();
        step();
        total++;
        if (a_state !== S_MEMWR || a_memwrite !== 1'b1) begin
            bad++;
            $display("FAIL rst_memwr_pre state=%0d memwrite=%b required 5 1", a_state, a_memwrite);
        end
        reset = 1'b1;
        #1;
        total++;
        if (a_memwrite !== 1'b0) begin
            bad++;
            $display("FAIL rst_memwr_gate memwrite=%b required 0", a_memwrite);
        end
        step();
        reset = 1'b0;
        #1;
        total++;
        if (a_state !== S_FETCH || a_memwrite !== 1'b0 || a_fault !== 1'b0) begin
            bad++;
            $display("FAIL rst_memwr state=%0d memwrite=%b fault=%b required 0 0 0", a_state, a_memwrite, a_fault);
        end
        $display("txn reset_in_memwr: state=%0d", a_state);
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_delay();
        test_branch();
        test_rtype();
        test_addi_jump();
        test_timeout();
        test_ready_wins();
        test_illegal();
        test_reset_memwr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
